keypad_scan_encoder: RTL



---
 rtl/keypad_scan_encoder_if.sv | 29 ++
 rtl/keypad_scan_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if
//   Pin bundle between the keypad matrix, the scan encoder and the 8051
//   mapping glue.
//   row_in     : keypad rows, active-low, pulled up, asynchronous to clk
//   col_out    : keypad columns, active-low, one-hot-low
//   key_code   : debounced key code (row*4 + col), to P1[7:4]
//   key_intr_n : active-low key interrupt, to P3_2 / INT0
//   modport master : the encoder side (drives columns, code, interrupt)
//   modport slave  : the keypad / microcontroller side
interface keypad_scan_encoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_intr_n;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_intr_n
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_intr_n
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Scans a 4x4 active-low keypad one column at a time, samples the rows
//   through a 2-flop synchronizer, reduces each full scan to NONE, SINGLE or
//   MULTI, and debounces over whole scans. The accepted code is held stable
//   while key_intr_n is low, so INT0 sees its falling edge with valid data.
//   Ports:
//     clk, rst : system clock, asynchronous active-high reset
//     bus      : keypad_scan_encoder_if.master (row_in, col_out, key_code,
//                key_intr_n)
//   Optional feature: define KEYPAD_TYPEMATIC_EN for auto-repeat; each repeat
//   raises key_intr_n for one full scan to produce a fresh falling edge.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  keypad_scan_encoder_if.master        bus
);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535 || DEBOUNCE_SCANS < 1 ||
      DEBOUNCE_SCANS > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan_encoder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t      state, state_n;
  logic [3:0]  row_s1, row_s2;
  logic [15:0] div_cnt;
  logic [1:0]  col_idx;
  logic        acc_found, acc_multi;
  logic [3:0]  acc_code;
  logic        found_t, multi_t;
  logic [3:0]  code_t;
  logic        tick, scan_done;
  logic [3:0]  cand, cand_n, cnt, cnt_n;
  logic [3:0]  key_code_q, code_n;
  logic        intr_q, intr_n_n;
`ifdef KEYPAD_TYPEMATIC_EN
  logic [15:0] rep_cnt, rep_cnt_n, rep_target, rep_inc;
  logic        rep_armed, rep_armed_n;
`endif

  assign tick      = (div_cnt == 16'(SCAN_DIV - 1));
  assign scan_done = tick && (col_idx == 2'd3);

  always_comb bus.col_out = ~(4'b0001 << col_idx);
  assign bus.key_code   = key_code_q;
  assign bus.key_intr_n = intr_q;

  // Stage: row synchronizer, prescaler and column scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else begin
      row_s1 <= bus.row_in;
      row_s2 <= row_s1;
      if (tick) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Fold this column's rows into the running scan result; rows ascending
  // within a column, columns ascending across the scan.
  always_comb begin
    found_t = acc_found;
    multi_t = acc_multi;
    code_t  = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (!found_t) begin
          found_t = 1'b1;
          code_t  = {2'(r), col_idx};
        end else begin
          multi_t = 1'b1;
        end
      end
    end
  end

  // Stage: scan accumulator, cleared after the column-3 sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_found <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (scan_done) begin
      acc_found <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (tick) begin
      acc_found <= found_t;
      acc_multi <= multi_t;
      acc_code  <= code_t;
    end
  end

  // Debounce FSM, advanced only on the column-3 tick using the completed
  // scan (including the column-3 sample taken in the same cycle).
  always_comb begin
    logic res_none, res_single;
    res_none   = !found_t;
    res_single = found_t && !multi_t;
    state_n    = state;
    cand_n     = cand;
    cnt_n      = cnt;
    code_n     = key_code_q;
    intr_n_n   = intr_q;
`ifdef KEYPAD_TYPEMATIC_EN
    rep_target  = rep_armed ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
    rep_inc     = rep_cnt + 16'd1;
    rep_cnt_n   = rep_cnt;
    rep_armed_n = rep_armed;
`endif
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (res_single) begin
            cand_n = code_t;
            cnt_n  = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              code_n   = code_t;
              intr_n_n = 1'b0;
              state_n  = HELD;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (res_single && code_t == cand) begin
            cnt_n = sat_inc(cnt);
            if (sat_inc(cnt) >= 4'(DEBOUNCE_SCANS)) begin
              code_n   = cand;
              intr_n_n = 1'b0;
              state_n  = HELD;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            cnt_n = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              intr_n_n = 1'b1;
              state_n  = IDLE;
            end else begin
              state_n = RELEASE_DB;
            end
          end else begin
`ifdef KEYPAD_TYPEMATIC_EN
            // A raised line here is a repeat pulse that has lasted one scan.
            if (intr_q) intr_n_n = 1'b0;
            if (res_single && code_t == key_code_q) begin
              if (rep_inc >= rep_target) begin
                intr_n_n    = 1'b1;
                rep_cnt_n   = 16'd0;
                rep_armed_n = 1'b1;
              end else begin
                rep_cnt_n = rep_inc;
              end
            end
`endif
          end
        end
        RELEASE_DB: begin
          if (res_none) begin
            cnt_n = sat_inc(cnt);
            if (sat_inc(cnt) >= 4'(DEBOUNCE_SCANS)) begin
              intr_n_n = 1'b1;
              state_n  = IDLE;
            end
          end else begin
            intr_n_n = 1'b0;
            state_n  = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
`ifdef KEYPAD_TYPEMATIC_EN
    if (state_n != HELD) begin
      rep_cnt_n   = 16'd0;
      rep_armed_n = 1'b0;
    end
`endif
  end

  // Stage: debounce state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= 4'h0;
      cnt        <= 4'h0;
      key_code_q <= 4'h0;
      intr_q     <= 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt    <= 16'd0;
      rep_armed  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      cnt        <= cnt_n;
      key_code_q <= code_n;
      intr_q     <= intr_n_n;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt    <= rep_cnt_n;
      rep_armed  <= rep_armed_n;
`endif
    end
  end

endmodule
